// File: rtl/mdu.sv
// mdu: multi-cycle mult/div unit with HI/LO registers; in clk, reset, E_MDU_opA, E_MDU_opB, E_MDUop, E_MDU_start; out E_MDU_busy, E_MDU_out
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_opA,
    input  logic [31:0] E_MDU_opB,
    input  logic [3:0]  E_MDUop,
    input  logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [31:0] hi, lo, pend_hi, pend_lo, res_hi, res_lo;
    logic [CW-1:0] cnt;
    logic [63:0] sprod, uprod;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, uq, ur, sq, sr;
    logic launch, is_mul, div_zero;
    assign is_mul = E_MDUop == 4'd1 || E_MDUop == 4'd2;
    assign launch = E_MDU_start && cnt == '0 && (is_mul || E_MDUop == 4'd3 || E_MDUop == 4'd4);
    assign sprod = {{32{E_MDU_opA[31]}}, E_MDU_opA} * {{32{E_MDU_opB[31]}}, E_MDU_opB};
    assign uprod = {32'd0, E_MDU_opA} * {32'd0, E_MDU_opB};
    assign div_zero = E_MDU_opB == 32'd0;
    assign a_mag = E_MDU_opA[31] ? -E_MDU_opA : E_MDU_opA;
    assign b_mag = E_MDU_opB[31] ? -E_MDU_opB : E_MDU_opB;
    assign b_safe = div_zero ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_safe;
    assign r_mag = a_mag % b_safe;
    assign sq = (E_MDU_opA[31] ^ E_MDU_opB[31]) ? -q_mag : q_mag;
    assign sr = E_MDU_opA[31] ? -r_mag : r_mag;
    assign uq = E_MDU_opA / (div_zero ? 32'd1 : E_MDU_opB);
    assign ur = E_MDU_opA % (div_zero ? 32'd1 : E_MDU_opB);
    always_comb begin
        res_hi = E_MDUop == 4'd1 ? sprod[63:32] : E_MDUop == 4'd2 ? uprod[63:32] : div_zero ? hi : E_MDUop == 4'd3 ? sr : ur;
        res_lo = E_MDUop == 4'd1 ? sprod[31:0] : E_MDUop == 4'd2 ? uprod[31:0] : div_zero ? lo : E_MDUop == 4'd3 ? sq : uq;
    end
    assign E_MDU_busy = cnt != '0;
    assign E_MDU_out = E_MDUop == 4'd7 ? hi : E_MDUop == 4'd8 ? lo : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt <= '0;
        end else if (launch) begin
            cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else begin
            if (E_MDUop == 4'd5) hi <= E_MDU_opA;
            if (E_MDUop == 4'd6) lo <= E_MDU_opA;
        end
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy duration of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy duration of div/divu in cycles.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port E_MDU_opA  input  32  E-stage rs operand, already forwarded.
REQ-006 SHALL have port E_MDU_opB  input  32  E-stage rt operand, already forwarded.
REQ-007 SHALL have port E_MDUop  input  4  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none.
REQ-008 SHALL have port E_MDU_start  input  1  launch strobe, valid only with ops 1-4.
REQ-009 SHALL have port E_MDU_busy  output  1  operation in flight; consumed by the hazard unit to stall D on any MDU-class instruction.
REQ-010 SHALL have port E_MDU_out  output  32  HI for op 7, LO for op 8, else 0; combinational from the current HI/LO registers.

Function
REQ-011 SHALL hold internal state: HI[31:0], LO[31:0], pending HI/LO [31:0] each, busy counter cnt.
REQ-012 SHALL accept a launch on an edge where E_MDU_start=1, E_MDUop is in 1-4 and cnt=0; at that edge it latches the pending result and loads cnt with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
REQ-013 SHALL drive E_MDU_busy = (cnt != 0); after a launch edge busy is high for exactly N cycles.
REQ-014 SHALL decrement cnt by 1 on each edge where cnt != 0; on the edge where cnt goes 1->0, HI/LO are loaded from the pending registers.
REQ-015 SHALL not change HI/LO during busy cycles; E_MDU_out for mfhi/mflo shows the pre-launch values until the completion edge.
REQ-016 SHALL compute mult as the signed 64-bit product and multu as the unsigned 64-bit product: HI = upper 32 bits, LO = lower 32 bits.
REQ-017 SHALL compute div as a signed quotient in LO, truncated toward zero, with the signed remainder in HI taking the dividend's sign.
REQ-018 SHALL compute divu as an unsigned quotient in LO and an unsigned remainder in HI.
REQ-019 SHALL leave HI/LO unchanged when the divisor is 0 (div/divu), while still asserting busy for DIV_CYCLES.
REQ-020 SHALL produce LO=0x80000000, HI=0 for div of 0x80000000 by 0xFFFFFFFF, with no trap.
REQ-021 SHALL ignore E_MDU_start while cnt != 0: no relaunch, no operand capture, cnt unaffected.
REQ-022 SHALL write HI <= E_MDU_opA on an edge with E_MDUop=5 (mthi) and cnt=0, independent of E_MDU_start; mtlo (op 6) does the same for LO.
REQ-023 SHALL ignore mthi/mtlo while cnt != 0.
REQ-024 SHALL give a launch precedence over mthi/mtlo, which cannot coincide because ops are mutually exclusive.
REQ-025 SHALL treat E_MDU_start with op 0 or 5-8 as a no-op with respect to launching.
REQ-026 SHALL treat a flushed E stage (bubble, start=0, op=0) as a no-op; an in-flight operation continues.

Reset
REQ-027 SHALL, while reset=1 at an edge, set HI=0, LO=0, pending=0 and cnt=0, making E_MDU_busy=0 from the following cycle.
REQ-028 SHALL, on reset during busy, abort the operation, discard the pending result and leave HI/LO at 0.
REQ-029 SHALL have reset take precedence over start, mthi and mtlo on the same edge.

Verification
REQ-030 SHALL verify: mult opA=0xFFFFFFFF, opB=2 -> busy for 5 cycles, then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFE.
REQ-031 SHALL verify: multu opA=0xFFFFFFFF, opB=2 -> HI=0x00000001 and LO=0xFFFFFFFE after 5 cycles; mflo sampled during busy returns the old LO.
REQ-032 SHALL verify: div opA=0xFFFFFFF9 (-7), opB=2 -> busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-033 SHALL verify: mthi 0x12345678, then divu with opB=0 -> busy for 10 cycles, HI stays 0x12345678, LO unchanged.
REQ-034 SHALL verify: start mult while busy with a div -> ignored, and the div result alone lands after its 10th cycle; mtlo issued while busy is also ignored.
REQ-035 SHALL verify: reset asserted on the 3rd busy cycle of a mult -> busy=0 on the next cycle, HI=LO=0, and no later update occurs.
